// File: rtl/key_event_gen_pkg.sv
// Shared types for key gesture decoding.
// Holds the FSM state type and the counter-width helper.
package key_evt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    GAP,
    PRESS2,
    LONG
  } key_state_t;

  localparam int DEF_LONG_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;
  localparam int DEF_DCLICK_CYCLES = 15_000_000;

  // Width that holds every terminal value (max - 1).
  function automatic int cnt_w(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/key_event_gen_if.sv
// Key level in, gesture events out.
// master: event generator; slave: event consumer.
interface key_event_if;

  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic click_pulse;
  logic dclick_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    input  key_level,
    output press_pulse,
    output release_pulse,
    output click_pulse,
    output dclick_pulse,
    output long_pulse,
    output repeat_pulse,
    output held
  );

  modport slave (
    output key_level,
    input  press_pulse,
    input  release_pulse,
    input  click_pulse,
    input  dclick_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  held
  );

endinterface

// File: rtl/key_event_gen.sv
// Debounced key level -> registered 1-cycle gesture events.
// Ports: clk, nrst (async, active-high), bus (key_event_if.master).
module key_event_gen
  import key_evt_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int DCLICK_CYCLES = DEF_DCLICK_CYCLES
) (
  input  logic clk,
  input  logic nrst,
  key_event_if.master bus
);

  localparam int CW =
    cnt_w(LONG_CYCLES, REPEAT_CYCLES, DCLICK_CYCLES);

  localparam logic [CW-1:0] LONG_T = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_T  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] DCL_T  = CW'(DCLICK_CYCLES - 1);

  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_prev;

  logic rise, fall;
  logic press_d, release_d, click_d;
  logic dclick_d, long_d, repeat_d, held_d;

  logic press_q, release_q, click_q;
  logic dclick_q, long_q, repeat_q, held_q;

  assign rise = bus.key_level & ~key_prev;
  assign fall = ~bus.key_level & key_prev;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Parked: hold cnt at 0 so it never runs away.
        cnt_d = '0;
        if (rise) begin
          state_d = PRESS;
          press_d = 1'b1;
        end
      end
      PRESS: begin
        if (fall) begin
          state_d   = GAP;
          release_d = 1'b1;
        end else if (cnt_q == LONG_T) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      GAP: begin
        if (rise) begin
          state_d  = PRESS2;
          press_d  = 1'b1;
          dclick_d = 1'b1;
        end else if (cnt_q == DCL_T) begin
          state_d = IDLE;
          click_d = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (cnt_q == LONG_T) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      LONG: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (cnt_q == REP_T) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    held_d = (state_d == PRESS) |
             (state_d == PRESS2) |
             (state_d == LONG);
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_prev  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_prev  <= bus.key_level;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.click_pulse   = click_q;
  assign bus.dclick_pulse  = dclick_q;
  assign bus.long_pulse    = long_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.held          = held_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen: directed table, corner sequences,
// and random key traffic against a gesture-level model.
module tb_key_event_gen;

  localparam int LONG = 8;
  localparam int REP  = 4;
  localparam int DCL  = 5;

  localparam logic [6:0] P  = 7'b1000000;
  localparam logic [6:0] R  = 7'b0100000;
  localparam logic [6:0] C  = 7'b0010000;
  localparam logic [6:0] D  = 7'b0001000;
  localparam logic [6:0] L  = 7'b0000100;
  localparam logic [6:0] RP = 7'b0000010;
  localparam logic [6:0] H  = 7'b0000001;
  localparam logic [6:0] Z  = 7'b0000000;

  logic clk;
  logic nrst;

  key_event_if bus ();

  key_event_gen #(
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP),
    .DCLICK_CYCLES(DCL)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  typedef struct {
    bit         rst;
    bit         key;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit k, logic [6:0] e);
    vec_t v;
    v.rst = r;
    v.key = k;
    v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic logic [6:0] outs();
    return {bus.press_pulse, bus.release_pulse,
            bus.click_pulse, bus.dclick_pulse,
            bus.long_pulse, bus.repeat_pulse, bus.held};
  endfunction

  // Apply inputs, let one edge pass, check registered outputs.
  task automatic step(input bit r, input bit k,
                      input logic [6:0] e, input string nm);
    logic [6:0] got;
    nrst = r;
    bus.key_level = k;
    @(posedge clk);
    #1;
    got = outs();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (p r c d l rp h)",
               nm, got, e);
    end
  endtask

  // Gesture-level reference: tracks hold time, gap time,
  // and whether the current press is the second of a pair.
  bit m_prev, m_down, m_second, m_long;
  int m_gap, m_hold, m_rep;

  function automatic logic [6:0] model_step(bit r, bit k);
    logic [6:0] e;
    e = '0;
    if (r) begin
      m_prev = 0; m_down = 0; m_second = 0; m_long = 0;
      m_gap = -1; m_hold = 0; m_rep = 0;
      return '0;
    end
    if (k && !m_prev) begin
      e |= P;
      m_second = (m_gap >= 0);
      if (m_second) e |= D;
      m_gap = -1; m_down = 1; m_hold = 0; m_long = 0;
    end else if (!k && m_prev) begin
      e |= R;
      m_down = 0;
      m_gap = (m_long || m_second) ? -1 : 0;
    end else if (m_down) begin
      m_hold++;
      if (m_long) begin
        m_rep++;
        if (m_rep == REP) begin
          e |= RP;
          m_rep = 0;
        end
      end else if (m_hold == LONG) begin
        e |= L;
        m_long = 1;
        m_rep = 0;
      end
    end else if (m_gap >= 0) begin
      m_gap++;
      if (m_gap == DCL) begin
        e |= C;
        m_gap = -1;
      end
    end
    m_prev = k;
    if (m_down) e |= H;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nrst = 1'b1;
    bus.key_level = 1'b0;

    // Reset with toggling key, then idle.
    add(1, 1, Z); add(1, 0, Z); add(1, 1, Z);
    add(0, 0, Z); add(0, 0, Z);
    // Short click.
    add(0, 1, P | H); add(0, 1, H); add(0, 1, H);
    add(0, 0, R);
    for (int i = 0; i < 4; i++) add(0, 0, Z);
    add(0, 0, C); add(0, 0, Z);
    // Double click: no click afterwards.
    add(0, 1, P | H); add(0, 1, H); add(0, 0, R);
    add(0, 0, Z); add(0, 1, P | D | H); add(0, 0, R);
    for (int i = 0; i < 7; i++) add(0, 0, Z);
    // Third fast press is a fresh single press.
    add(0, 1, P | H); add(0, 0, R);
    add(0, 1, P | D | H); add(0, 0, R);
    add(0, 1, P | H); add(0, 0, R);
    for (int i = 0; i < 4; i++) add(0, 0, Z);
    add(0, 0, C);
    // Release exactly at long expiry: edge wins.
    add(0, 1, P | H);
    for (int i = 0; i < 7; i++) add(0, 1, H);
    add(0, 0, R);
    for (int i = 0; i < 4; i++) add(0, 0, Z);
    add(0, 0, C);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].key, tbl[i].exp,
           $sformatf("table[%0d]", i));

    // Long hold with three repeats, then release, no click.
    for (int i = 0; i <= 20; i++) begin
      logic [6:0] e;
      e = H;
      if (i == 0) e |= P;
      if (i == LONG) e |= L;
      if (i == 12 || i == 16 || i == 20) e |= RP;
      step(0, 1, e, $sformatf("long[%0d]", i));
    end
    step(0, 0, R, "long_release");
    for (int i = 0; i < 7; i++)
      step(0, 0, Z, $sformatf("long_noclick[%0d]", i));

    // Reset mid-LONG with key still held.
    step(0, 1, P | H, "rl_press");
    for (int i = 1; i <= 9; i++)
      step(0, 1, (i == LONG) ? (L | H) : H,
           $sformatf("rl_hold[%0d]", i));
    step(1, 1, Z, "rl_rst0");
    step(1, 1, Z, "rl_rst1");
    step(0, 1, P | H, "rl_repress");
    step(0, 0, R, "rl_release");

    // Random traffic against the model.
    begin
      bit k;
      int run;
      void'(model_step(1, 0));
      step(1, 0, Z, "rand_rst");
      k = 0;
      run = 0;
      for (int c = 0; c < 3000; c++) begin
        bit r;
        logic [6:0] e;
        if (run == 0) begin
          k = ~k;
          run = $urandom_range(1, 14);
        end
        run--;
        r = ($urandom_range(0, 249) == 0);
        e = model_step(r, k);
        step(r, k, e, $sformatf("rand[%0d]", c));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
